clq_list_walker: RTL and testbench
==================================

# clq_list_walker

Reader-side companion of the clause queue (CLQ) in the lookup stage. On each unit literal from the UCQ/UCarb side it requests that literal's dummy-head pointer from the CLQ and follows the linked list of clause nodes through the CLQ read port (`cnf_idx` → `node`). It streams every clause node to the BCP compute unit over a valid/ready handshake, then reports completion. It is the consumer of the per-literal lists that the clause arbiter (Carb) builds.

## Interface
Parameters:
- `DEPTH`, 16: CLQ node capacity; also the loop-guard limit.
- `PTR_W`, `$clog2(DEPTH)+1`: width of `ptr_t`. MSB = 1 means NULL. The low `$clog2(DEPTH)` bits are the buffer index.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Synchronous and active-high despite the name; asserted = 1.
- `uc_in`  in  `lit_t`  unit literal to propagate.
- `uc_in_valid`  in  1  `uc_in` valid.
- `uc_in_ready`  out  1  walker can accept a literal.
- `wlk2clq_uc_rqst`  out  `lit_t`  head-pointer request literal.
- `wlk2clq_uc_rqst_valid`  out  1  request strobe.
- `clq2wlk_init_ptr`  in  `PTR_W`  head pointer. Combinational response in the same cycle.
- `clq2wlk_init_ptr_valid`  in  1  head pointer valid.
- `wlk2clq_cnf_idx`  out  `PTR_W`  node read address.
- `clq2wlk_node`  in  `node_t`  node at `wlk2clq_cnf_idx`. Combinational, same cycle. Fields: `.next` (`ptr_t`), `.clause`.
- `clause_out`  out  `node_t`  clause node for BCP.
- `clause_out_lit`  out  `lit_t`  literal being propagated.
- `clause_out_valid`  out  1.
- `clause_out_ready`  in  1.
- `abort`  in  1  conflict flush.
- `done`  out  1  one-cycle completion pulse.
- `done_count`  out  `PTR_W`  number of clauses emitted for this literal. Valid with `done`.
- `err_loop`  out  1  one-cycle pulse when the loop guard trips. Coincides with `done`.

## Operation
States: IDLE, LOOKUP, WALK, DONE.

- **IDLE**
  - `uc_in_ready` = 1.
  - On `uc_in_valid`: latch `uc_in`, clear the step counter, go to LOOKUP.
- **LOOKUP**
  - Drive `wlk2clq_uc_rqst` = latched literal and `wlk2clq_uc_rqst_valid` = 1 for exactly one cycle.
  - Register `clq2wlk_init_ptr` into `cur_ptr`.
  - If the pointer is NULL or `clq2wlk_init_ptr_valid` = 0, go to DONE. Otherwise go to WALK.
- **WALK**
  - `wlk2clq_cnf_idx` = `cur_ptr` whenever `cur_ptr` is non-NULL.
  - Load condition: `cur_ptr` non-NULL and (`clause_out_valid` = 0 or `clause_out_ready` = 1).
  - On a load: `clause_out` ← `clq2wlk_node`, `clause_out_valid` ← 1, `cur_ptr` ← `node.next`, step counter +1.
  - If the handshake completes and `cur_ptr` is NULL: `clause_out_valid` ← 0, go to DONE.
  - While stalled, `clause_out`, `clause_out_lit`, `wlk2clq_cnf_idx` and `cur_ptr` hold stable.
- **Loop guard**
  - If the step counter equals `DEPTH` and `cur_ptr` is still non-NULL, no further load occurs.
  - After the last handshake, go to DONE with `err_loop` = 1.
- **DONE**
  - `done` = 1 and `done_count` = step counter for one cycle, then go to IDLE.
- **Abort**
  - `abort` = 1 in any state: next state IDLE, `clause_out_valid` ← 0, no `done` pulse.
  - Abort has priority over every other event, including a same-cycle `uc_in_valid` in IDLE, which is not accepted.
- **Arithmetic**
  - Step counter is `PTR_W` bits and saturates at `DEPTH`.
  - `clause_out_lit` = latched literal for the whole walk.

## Timing
- **Reset:** while `rst_n` = 1 the state is IDLE. All outputs are 0, including `uc_in_ready`, `done`, `done_count`, `err_loop`, `clause_out_valid`, `clause_out`, `wlk2clq_uc_rqst_valid` and `wlk2clq_cnf_idx`. `uc_in_ready` = 1 from the first cycle after deassertion. Reset asserted mid-walk discards the walk: no `done` pulse.
- **Cycle numbering:** literal accepted in cycle T → LOOKUP in T+1 → first node read in T+2 → `clause_out_valid` from T+3.
- **Throughput:** one clause per cycle while `clause_out_ready` = 1.
- **Done:** the `done` pulse occurs in the cycle after the last clause handshake. For an empty list, `done` occurs at T+2.
- **Accept rate:** at most one literal is accepted per walk. The next accept is possible in the cycle after `done`.

## Test plan
- **Empty list:** `uc_in` = 0x05, `init_ptr` = NULL → no `clause_out_valid`; `done` at T+2 with `done_count` = 0; `uc_in_ready` = 1 at T+3.
- **Chain 2→7→4→NULL, ready tied 1:** `clause_out` = nodes 2, 7, 4 in T+3, T+4, T+5 with `clause_out_lit` = `uc_in`; `done` at T+6 with `done_count` = 3.
- **Backpressure:** same chain, `clause_out_ready` = 0 for 4 cycles while node 7 is presented → node 7, `cnf_idx` = 4 and `cur_ptr` stay stable; no node skipped or duplicated; `done_count` = 3.
- **Loop 1→3→1:** 16 clauses emitted, then `done` with `err_loop` = 1 and `done_count` = 16.
- **Abort:** `abort` during the second clause of a 3-chain → IDLE next cycle, `clause_out_valid` = 0, no `done`. A new literal accepted the following cycle completes normally.
- **Reset mid-walk:** `rst_n` = 1 for 2 cycles during WALK → all outputs 0, no `done`. After release the walker accepts a new literal.

Source files
------------

// File: rtl/clq_list_walker.sv
`default_nettype none
// ============================================================================
// Module   : clq_list_walker
// Purpose  : Reader-side walker for the clause queue. For each unit literal it
//            fetches the literal's head pointer from the CLQ, follows the
//            linked list of clause nodes through the CLQ read port and streams
//            every node to BCP over a valid/ready handshake, then pulses done.
// Ports    : clk, rst_n (synchronous, active-high despite the name)
//            uc_in/_valid/_ready            - unit literal input
//            wlk2clq_uc_rqst/_valid         - head-pointer request to CLQ
//            clq2wlk_init_ptr/_valid        - head pointer (same-cycle)
//            wlk2clq_cnf_idx, clq2wlk_node  - node read port (same-cycle)
//            clause_out/_lit/_valid/_ready  - clause stream to BCP
//            abort                          - conflict flush
//            done, done_count, err_loop     - completion report
// Node     : {next[PTR_W-1:0], clause[CLAUSE_W-1:0]}, next in the MSBs.
//            Pointer MSB = 1 means NULL.
// Revision : 1.0 - initial release
// ============================================================================
module clq_list_walker #(
    parameter int DEPTH    = 16,
    parameter int PTR_W    = $clog2(DEPTH) + 1,
    parameter int LIT_W    = 8,
    parameter int CLAUSE_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LIT_W-1:0]          uc_in,
    input  logic                      uc_in_valid,
    output logic                      uc_in_ready,
    output logic [LIT_W-1:0]          wlk2clq_uc_rqst,
    output logic                      wlk2clq_uc_rqst_valid,
    input  logic [PTR_W-1:0]          clq2wlk_init_ptr,
    input  logic                      clq2wlk_init_ptr_valid,
    output logic [PTR_W-1:0]          wlk2clq_cnf_idx,
    input  logic [PTR_W+CLAUSE_W-1:0] clq2wlk_node,
    output logic [PTR_W+CLAUSE_W-1:0] clause_out,
    output logic [LIT_W-1:0]          clause_out_lit,
    output logic                      clause_out_valid,
    input  logic                      clause_out_ready,
    input  logic                      abort,
    output logic                      done,
    output logic [PTR_W-1:0]          done_count,
    output logic                      err_loop
);

    localparam int               NODE_W  = PTR_W + CLAUSE_W;
    localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_WALK   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [LIT_W-1:0]  r_lit;
    logic [PTR_W-1:0]  r_cur_ptr;
    logic [PTR_W-1:0]  r_step;
    logic [NODE_W-1:0] r_clause_out;
    logic              r_clause_valid;

    logic              w_cur_null;
    logic              w_sat;
    logic              w_slot_free;
    logic              w_load;
    logic              w_walk_end;
    logic              w_accept;
    logic              w_init_null;
    logic [PTR_W-1:0]  w_node_next;

    assign w_cur_null  = r_cur_ptr[PTR_W-1];
    assign w_sat       = (r_step == C_DEPTH);
    // Output slot can take a new node when empty or being drained this cycle.
    assign w_slot_free = !r_clause_valid || clause_out_ready;
    // Loop guard: once DEPTH nodes have been emitted no further load happens,
    // even if the list still points somewhere.
    assign w_load      = (r_state == S_WALK) && !w_cur_null && !w_sat && w_slot_free;
    // Walk finishes once nothing more can be loaded and the last node is gone.
    assign w_walk_end  = (r_state == S_WALK) && w_slot_free && (w_cur_null || w_sat);
    assign w_accept    = (r_state == S_IDLE) && uc_in_valid && !abort;
    assign w_init_null = !clq2wlk_init_ptr_valid || clq2wlk_init_ptr[PTR_W-1];
    assign w_node_next = clq2wlk_node[NODE_W-1 -: PTR_W];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (uc_in_valid) w_state_nxt = S_LOOKUP;
            S_LOOKUP: w_state_nxt = w_init_null ? S_DONE : S_WALK;
            S_WALK:   if (w_walk_end) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle accept.
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_lit          <= '0;
            r_cur_ptr      <= '0;
            r_step         <= '0;
            r_clause_out   <= '0;
            r_clause_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lit  <= uc_in;
                r_step <= '0;
            end
            if (r_state == S_LOOKUP) begin
                r_cur_ptr <= clq2wlk_init_ptr;
            end
            if (w_load) begin
                r_clause_out   <= clq2wlk_node;
                r_clause_valid <= 1'b1;
                r_cur_ptr      <= w_node_next;
                r_step         <= r_step + PTR_W'(1);
            end else if (w_walk_end) begin
                r_clause_valid <= 1'b0;
            end
            if (abort) begin
                r_clause_valid <= 1'b0;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        uc_in_ready           = 1'b0;
        wlk2clq_uc_rqst       = '0;
        wlk2clq_uc_rqst_valid = 1'b0;
        wlk2clq_cnf_idx       = '0;
        done                  = 1'b0;
        done_count            = '0;
        err_loop              = 1'b0;
        // All handshake/report outputs are forced low while reset is held.
        if (!rst_n) begin
            case (r_state)
                S_IDLE: begin
                    uc_in_ready = !abort;
                end
                S_LOOKUP: begin
                    wlk2clq_uc_rqst       = r_lit;
                    wlk2clq_uc_rqst_valid = 1'b1;
                end
                S_WALK: begin
                    wlk2clq_cnf_idx = w_cur_null ? '0 : r_cur_ptr;
                end
                S_DONE: begin
                    if (!abort) begin
                        done       = 1'b1;
                        done_count = r_step;
                        // cur_ptr is frozen once the guard trips, so a
                        // saturated count with a live pointer means a loop.
                        err_loop   = w_sat && !w_cur_null;
                    end
                end
                default: begin
                    uc_in_ready = 1'b0;
                end
            endcase
        end
    end

    assign clause_out       = r_clause_out;
    assign clause_out_valid = r_clause_valid;
    assign clause_out_lit   = r_lit;

endmodule
`default_nettype wire

// File: tb/tb_clq_list_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_clq_list_walker
// Purpose  : Self-checking bench for clq_list_walker. A behavioural CLQ
//            (head pointer + node array) answers the walker; the expected
//            clause sequence is obtained by following the list in plain code.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clq_list_walker;

    localparam int DEPTH    = 16;
    localparam int PTR_W    = 5;
    localparam int LIT_W    = 8;
    localparam int CLAUSE_W = 16;
    localparam int NODE_W   = PTR_W + CLAUSE_W;
    localparam logic [PTR_W-1:0] NULLP = 5'h10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [LIT_W-1:0]     uc_in;
    logic                 uc_in_valid;
    logic                 uc_in_ready;
    logic [LIT_W-1:0]     wlk2clq_uc_rqst;
    logic                 wlk2clq_uc_rqst_valid;
    logic [PTR_W-1:0]     clq2wlk_init_ptr;
    logic                 clq2wlk_init_ptr_valid;
    logic [PTR_W-1:0]     wlk2clq_cnf_idx;
    logic [NODE_W-1:0]    clq2wlk_node;
    logic [NODE_W-1:0]    clause_out;
    logic [LIT_W-1:0]     clause_out_lit;
    logic                 clause_out_valid;
    logic                 clause_out_ready;
    logic                 abort;
    logic                 done;
    logic [PTR_W-1:0]     done_count;
    logic                 err_loop;

    logic [PTR_W-1:0]     mem_next   [DEPTH];
    logic [CLAUSE_W-1:0]  mem_clause [DEPTH];

    logic [NODE_W-1:0]    exp_q[$];
    logic [PTR_W-1:0]     exp_nxt[$];
    bit                   exp_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign clq2wlk_node = {mem_next[wlk2clq_cnf_idx[PTR_W-2:0]],
                           mem_clause[wlk2clq_cnf_idx[PTR_W-2:0]]};

    clq_list_walker #(
        .DEPTH(DEPTH), .PTR_W(PTR_W), .LIT_W(LIT_W), .CLAUSE_W(CLAUSE_W)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .uc_in                  (uc_in),
        .uc_in_valid            (uc_in_valid),
        .uc_in_ready            (uc_in_ready),
        .wlk2clq_uc_rqst        (wlk2clq_uc_rqst),
        .wlk2clq_uc_rqst_valid  (wlk2clq_uc_rqst_valid),
        .clq2wlk_init_ptr       (clq2wlk_init_ptr),
        .clq2wlk_init_ptr_valid (clq2wlk_init_ptr_valid),
        .wlk2clq_cnf_idx        (wlk2clq_cnf_idx),
        .clq2wlk_node           (clq2wlk_node),
        .clause_out             (clause_out),
        .clause_out_lit         (clause_out_lit),
        .clause_out_valid       (clause_out_valid),
        .clause_out_ready       (clause_out_ready),
        .abort                  (abort),
        .done                   (done),
        .done_count             (done_count),
        .err_loop               (err_loop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Reference: follow the list from the head, at most DEPTH nodes.
    task automatic build_expect();
        logic [PTR_W-1:0] p;
        int n;
        exp_q.delete();
        exp_nxt.delete();
        p = clq2wlk_init_ptr_valid ? clq2wlk_init_ptr : NULLP;
        n = 0;
        while (!p[PTR_W-1] && n < DEPTH) begin
            exp_q.push_back({mem_next[p[PTR_W-2:0]], mem_clause[p[PTR_W-2:0]]});
            p = mem_next[p[PTR_W-2:0]];
            exp_nxt.push_back(p);
            n++;
        end
        exp_err = !p[PTR_W-1];
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) begin
            mem_clause[i] = CLAUSE_W'($urandom);
            mem_next[i]   = {1'b1, 4'($urandom)};
        end
    endtask

    task automatic set_chain_274();
        fill_mem();
        mem_next[2] = 5'd7;
        mem_next[7] = 5'd4;
        mem_next[4] = NULLP;
        clq2wlk_init_ptr       = 5'd2;
        clq2wlk_init_ptr_valid = 1'b1;
    endtask

    task automatic set_loop_131();
        fill_mem();
        mem_next[1] = 5'd3;
        mem_next[3] = 5'd1;
        clq2wlk_init_ptr       = 5'd1;
        clq2wlk_init_ptr_valid = 1'b1;
    endtask

    task automatic make_random_list(input int len, input bit make_loop);
        int perm[DEPTH];
        int j, t;
        fill_mem();
        for (int i = 0; i < DEPTH; i++) perm[i] = i;
        for (int i = DEPTH - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int k = 0; k + 1 < len; k++) mem_next[perm[k]] = PTR_W'(perm[k+1]);
        if (len > 0) begin
            if (make_loop) mem_next[perm[len-1]] = PTR_W'(perm[$urandom_range(0, len-1)]);
            else           mem_next[perm[len-1]] = {1'b1, 4'($urandom)};
            clq2wlk_init_ptr = PTR_W'(perm[0]);
        end else begin
            clq2wlk_init_ptr = {1'b1, 4'($urandom)};
        end
        clq2wlk_init_ptr_valid = ($urandom_range(0, 7) != 0);
    endtask

    // One complete walk. Called just after a posedge; returns just after one.
    // mode 0: ready tied 1, 1: random ready, 2: 4-cycle stall on 2nd clause.
    task automatic walk(input string tag, input logic [LIT_W-1:0] lit,
                        input int mode, input bit chk_abort);
        int  t_acc, first_v, last_hs, done_cyc, hs, n_stall;
        bit  got_done;
        build_expect();
        uc_in = lit;
        uc_in_valid = 1'b1;
        clause_out_ready = 1'b1;
        @(negedge clk);
        check({tag, ".accept_ready"}, uc_in_ready, 1);
        if (chk_abort) begin
            check({tag, ".abort_valid"}, clause_out_valid, 0);
            check({tag, ".abort_done"}, done, 0);
        end
        t_acc = cyc;
        @(posedge clk); #1;
        uc_in_valid = 1'b0;
        uc_in = LIT_W'($urandom);
        hs = 0; first_v = -1; last_hs = -1; done_cyc = -1; n_stall = 0; got_done = 0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            case (mode)
                0:       clause_out_ready = 1'b1;
                1:       clause_out_ready = 1'($urandom_range(0, 1));
                default: clause_out_ready = !(hs == 1 && n_stall < 4);
            endcase
            @(negedge clk);
            if (cyc == t_acc + 1) begin
                check({tag, ".rqst_valid"}, wlk2clq_uc_rqst_valid, 1);
                check({tag, ".rqst_lit"}, wlk2clq_uc_rqst, lit);
            end
            if (clause_out_valid) begin
                if (first_v < 0) first_v = cyc;
                check({tag, ".clause_lit"}, clause_out_lit, lit);
                if (hs < exp_q.size()) check({tag, ".clause"}, clause_out, exp_q[hs]);
                else                   check({tag, ".extra_clause"}, 1, 0);
                if (!clause_out_ready) begin
                    n_stall++;
                    if (hs < exp_nxt.size())
                        check({tag, ".stall_idx"}, wlk2clq_cnf_idx,
                              exp_nxt[hs][PTR_W-1] ? '0 : exp_nxt[hs]);
                end else begin
                    hs++;
                    last_hs = cyc;
                end
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                check({tag, ".done_count"}, done_count, exp_q.size());
                check({tag, ".err_loop"}, err_loop, exp_err);
            end
            @(posedge clk); #1;
        end
        check({tag, ".done_seen"}, got_done, 1);
        check({tag, ".n_clauses"}, hs, exp_q.size());
        if (exp_q.size() > 0) begin
            check({tag, ".first_valid_cyc"}, first_v - t_acc, 3);
            check({tag, ".done_cyc"}, done_cyc - last_hs, 1);
            if (mode == 0) check({tag, ".throughput"}, done_cyc - t_acc, 3 + exp_q.size());
        end else begin
            check({tag, ".empty_done_cyc"}, done_cyc - t_acc, 2);
        end
        @(negedge clk);
        check({tag, ".ready_after"}, uc_in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".uc_in_ready"}, uc_in_ready, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".done_count"}, done_count, 0);
        check({tag, ".err_loop"}, err_loop, 0);
        check({tag, ".clause_valid"}, clause_out_valid, 0);
        check({tag, ".clause_out"}, clause_out, 0);
        check({tag, ".rqst_valid"}, wlk2clq_uc_rqst_valid, 0);
        check({tag, ".cnf_idx"}, wlk2clq_cnf_idx, 0);
    endtask

    initial begin
        bit fired;
        int hs;
        rst_n = 1'b1;
        uc_in = '0;
        uc_in_valid = 1'b0;
        clause_out_ready = 1'b0;
        abort = 1'b0;
        clq2wlk_init_ptr = NULLP;
        clq2wlk_init_ptr_valid = 1'b0;
        fill_mem();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b0;

        // Empty list
        fill_mem();
        clq2wlk_init_ptr = NULLP;
        clq2wlk_init_ptr_valid = 1'b1;
        walk("empty", 8'h05, 0, 0);

        // Chain 2->7->4, full rate then with backpressure on node 7
        set_chain_274();
        walk("chain", 8'h3c, 0, 0);
        set_chain_274();
        walk("bp", 8'ha7, 2, 0);

        // Loop 1->3->1 trips the guard
        set_loop_131();
        walk("loop", 8'h11, 0, 0);

        // Abort while the second clause is presented
        set_chain_274();
        build_expect();
        uc_in = 8'h42;
        uc_in_valid = 1'b1;
        clause_out_ready = 1'b1;
        @(posedge clk); #1;
        uc_in_valid = 1'b0;
        fired = 0;
        hs = 0;
        for (int i = 0; i < 20 && !fired; i++) begin
            @(negedge clk);
            if (clause_out_valid) begin
                if (hs == 1) begin
                    abort = 1'b1;
                    fired = 1;
                end
                hs++;
            end
            if (!fired) begin
                @(posedge clk); #1;
            end
        end
        check("abort.reached", fired, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        set_chain_274();
        walk("after_abort", 8'h99, 0, 1);

        // Abort coinciding with a literal in IDLE: literal is dropped
        uc_in = 8'h77;
        uc_in_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        uc_in_valid = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort.no_lookup", wlk2clq_uc_rqst_valid, 0);
        check("idle_abort.still_idle", uc_in_ready, 1);
        @(posedge clk); #1;

        // Reset mid-walk
        set_loop_131();
        uc_in = 8'h5a;
        uc_in_valid = 1'b1;
        clause_out_ready = 1'b1;
        @(posedge clk); #1;
        uc_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("post_reset.ready", uc_in_ready, 1);
        check("post_reset.done", done, 0);
        check("post_reset.valid", clause_out_valid, 0);
        @(posedge clk); #1;
        set_chain_274();
        walk("post_reset", 8'hc3, 0, 0);

        // Randomised lists, lengths and backpressure
        for (int r = 0; r < 24; r++) begin
            make_random_list($urandom_range(0, 7), ($urandom_range(0, 3) == 0));
            walk("rand", LIT_W'($urandom), $urandom_range(0, 1), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
